// File: rtl/debug_pkg.sv
// Shared constants and helpers for the debug panel blocks (display and keypad).
package debug_pkg;

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned FRAME_W = 16;

  // Column 0 driven low; the other columns are released.
  localparam logic [3:0] COL_RESET = 4'b1110;

  function automatic logic is_onehot(input logic [FRAME_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FRAME_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n == 1;
  endfunction

endpackage

// File: rtl/debug_sync2.sv
// Two-flop synchronizer for slow asynchronous inputs on the debug panel.
module debug_sync2 #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debug_keypad.sv
// 4x4 matrix keypad scanner: column scan, frame debounce and a one-entry
// valid/ack holding register for single-key press codes.
module debug_keypad
  import debug_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_down,
  output logic             overrun
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);

  logic [3:0]         row_sync;
  logic [3:0]         pressed;
  logic [DIV_W-1:0]   div_q;
  logic [1:0]         col_idx_q;
  logic [3:0]         col_q;
  logic [FRAME_W-1:0] snap_q, prev_q, deb_q;
  logic [CNT_W-1:0]   stable_q, stable_d;
  logic               ev_q;
  logic [KEY_W-1:0]   ev_code_q;

  logic               tick, frame_end, deb_upd, new_ev;
  logic [FRAME_W-1:0] frame;
  logic [KEY_W-1:0]   ev_idx;

  debug_sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_sync)
  );

  assign pressed   = ~row_sync;
  assign tick      = (div_q == '0);
  assign frame_end = tick && (col_idx_q == 2'd3);
  assign col       = col_q;

  always_comb begin
    // Completed frame: stored slots plus the slot being sampled on this tick.
    frame = snap_q;
    frame[{col_idx_q, 2'b00} +: 4] = pressed;

    stable_d = stable_q;
    if (frame != prev_q) begin
      stable_d = '0;
    end else if (stable_q != DEB_MAX) begin
      stable_d = stable_q + 1'b1;
    end

    deb_upd = frame_end && (stable_d == DEB_MAX) && (frame != deb_q);
    new_ev  = deb_upd && (deb_q == '0) && is_onehot(frame);

    ev_idx = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      if (frame[i]) ev_idx = KEY_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Load a full slot so column 0 settles as long as every other column.
      div_q     <= DIV_LOAD;
      col_idx_q <= '0;
      col_q     <= COL_RESET;
      snap_q    <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      stable_q  <= '0;
      ev_q      <= 1'b0;
      ev_code_q <= '0;
      key_down  <= 1'b0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      key_down <= |deb_q;
      ev_q     <= new_ev;
      if (new_ev) ev_code_q <= ev_idx;

      if (tick) begin
        div_q                          <= DIV_LOAD;
        snap_q[{col_idx_q, 2'b00} +: 4] <= pressed;
        col_idx_q                      <= col_idx_q + 2'd1;
        col_q                          <= {col_q[2:0], col_q[3]};
      end else begin
        div_q <= div_q - 1'b1;
      end

      if (frame_end) begin
        stable_q <= stable_d;
        prev_q   <= frame;
        if (deb_upd) deb_q <= frame;
      end

      if (ev_q) begin
        if (!key_valid) begin
          key_code  <= ev_code_q;
          key_valid <= 1'b1;
        end else if (key_ack) begin
          key_code <= ev_code_q;
          overrun  <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_keypad.sv
// Scoreboard bench for debug_keypad: a key-matrix board model drives the rows,
// expected press codes are queued by the stimulus and popped by a monitor.
module tb_debug_keypad;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEBOUNCE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_down;
  logic       overrun;

  logic [15:0] keys = '0;  // keys[c*4+r]: switch at column c, row r closed
  logic [3:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        ack_at_edge = 1'b0;
  logic        prev_valid = 1'b0;
  logic [3:0]  exp_code;

  always #5 clk = ~clk;

  debug_keypad #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  // Passive matrix: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    ack_at_edge = key_ack;
  end

  // A delivery is key_valid rising, or key_valid held across an acknowledged edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (key_valid && (!prev_valid || ack_at_edge)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0d, expected none at %0t", key_code, $time);
        end else begin
          exp_code = exp_q.pop_front();
          check("event_code", int'(key_code), int'(exp_code));
        end
      end
      prev_valid = key_valid;
    end
  end

  task automatic wait_frame_end();
    logic [3:0] last;
    int         n;
    last = col;
    n    = 0;
    while (n < 40) begin
      @(negedge clk);
      if (col == 4'b1110 && last == 4'b0111) return;
      last = col;
      n++;
    end
    check("frame_end_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) wait_frame_end();
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!key_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(key_valid), 1);
  endtask

  task automatic wait_released();
    int n;
    n = 0;
    while (key_down && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("release_key_down", int'(key_down), 0);
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    check("ack_valid_clear", int'(key_valid), 0);
    check("ack_overrun_clear", int'(overrun), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, int'(col), 4'b1110);
    check({tag, "_code"}, int'(key_code), 0);
    check({tag, "_valid"}, int'(key_valid), 0);
    check({tag, "_down"}, int'(key_down), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  initial begin
    logic [3:0] prevc;
    int         run;
    bit         first;
    bit         idle_bad;
    int         k;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle scan order and slot length.
    prevc    = col;
    run      = 0;
    first    = 1'b1;
    idle_bad = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (col == prevc) begin
        run++;
      end else begin
        check("col_order", int'(col), int'({prevc[2:0], prevc[3]}));
        if (!first) check("col_hold", run, SCAN_DIV);
        first = 1'b0;
        run   = 1;
        prevc = col;
      end
      if (key_valid || key_down) idle_bad = 1'b1;
    end
    check("idle_flags", int'(idle_bad), 0);

    // Single press of key 6.
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_valid("key6_valid", 100);
    check("key6_down", int'(key_down), 1);
    pulse_ack();
    keys = '0;
    wait_released();

    // Bouncing contact, then a clean hold: one event only.
    repeat (10) begin
      keys[6] = ~keys[6];
      repeat (10) @(negedge clk);
    end
    check("bounce_no_event", int'(key_valid), 0);
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_valid("bounce_valid", 120);
    pulse_ack();
    keys = '0;
    wait_released();

    // Two keys together produce no event; a lone key afterwards does.
    keys = 16'h0240;
    wait_frames(8);
    check("ghost_down", int'(key_down), 1);
    check("ghost_no_event", int'(key_valid), 0);
    keys = '0;
    wait_released();
    wait_frames(2);
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid("key9_valid", 120);
    pulse_ack();
    keys = '0;
    wait_released();

    // Lost press sets overrun and keeps the held code.
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_valid("key3_valid", 120);
    keys = '0;
    wait_released();
    wait_frames(1);
    wait_frame_end();
    keys[12] = 1'b1;
    wait_frames(6);
    check("overrun_code", int'(key_code), 3);
    check("overrun_valid", int'(key_valid), 1);
    check("overrun_flag", int'(overrun), 1);
    pulse_ack();
    keys = '0;
    wait_released();

    // Ack in the same clock as the next event: new code replaces the old one.
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_valid("key3b_valid", 120);
    keys = '0;
    wait_released();
    wait_frames(1);
    wait_frame_end();
    keys[12] = 1'b1;
    exp_q.push_back(4'd12);
    // Press lands in the frame after this edge; DEBOUNCE more matching frames accept it.
    wait_frames(DEBOUNCE + 1);
    key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    check("same_clk_code", int'(key_code), 12);
    check("same_clk_valid", int'(key_valid), 1);
    check("same_clk_overrun", int'(overrun), 0);
    pulse_ack();
    keys = '0;
    wait_released();

    // Reset mid-frame with key 5 debounced; it is re-detected afterwards.
    keys[5] = 1'b1;
    exp_q.push_back(4'd5);
    wait_valid("key5_valid", 120);
    wait_frame_end();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.push_back(4'd5);
    wait_valid("key5_again", 120);
    check("key5_again_down", int'(key_down), 1);
    pulse_ack();
    keys = '0;
    wait_released();

    // Random single presses with random timing.
    repeat (6) begin
      k = int'($urandom_range(15, 0));
      repeat ($urandom_range(20, 0)) @(negedge clk);
      keys[k] = 1'b1;
      exp_q.push_back(4'(k));
      wait_valid("rand_valid", 120);
      repeat ($urandom_range(10, 0)) @(negedge clk);
      pulse_ack();
      keys = '0;
      wait_released();
    end

    wait_frames(2);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_keypad.md
Name: debug_keypad

Overview:
- 4x4 matrix keypad scanner for the debug panel; input counterpart of the multiplexed 7-segment debug display.
- Drives one column low at a time and samples the active-low row lines, one column per scan slot.
- Debounces the full 16-key frame and delivers single-key press codes through a one-entry valid/ack holding register.
- Sits next to the debug display; consumers are debug/monitor logic.

Parameters:
- SCAN_DIV, 1000, clocks per column slot; must be >= 4.
- DEBOUNCE, 8, consecutive identical frame comparisons required to accept a new key state; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row  in  4  keypad row lines, active-low (board pull-ups), asynchronous to clk
- col  out  4  keypad column drives, active-low, exactly one bit low at any time
- key_code  out  4  code of last accepted press; code = col_index*4 + row_index
- key_valid  out  1  holding register full; stays high until key_ack
- key_ack  in  1  consumer acknowledge; a one-clock pulse consumes the held code
- key_down  out  1  debounced state has at least one key pressed
- overrun  out  1  sticky flag: a press was lost while key_valid=1; cleared by key_ack or reset

Behaviour:
- Reset values: col=4'b1110 (column 0), key_code=0, key_valid=0, key_down=0, overrun=0. Prescaler, column index, snapshot, previous snapshot, debounced state and stable counter are all cleared. Reset mid-scan aborts the frame; no event is generated.
- Synchronizer: row passes through 2 flops; the sampled value is inverted so that 1 means pressed.
- Prescaler: counts SCAN_DIV-1 down to 0. The tick is the clock where the count is 0.
- On tick: store the synced row bits into snapshot[col_index*4 +: 4], then advance col_index (3 wraps to 0) and drive the next column.
- A column is driven for SCAN_DIV clocks before it is sampled, so settle time exceeds the synchronizer latency.
- Frame end is the tick with col_index=3. The frame period is 4*SCAN_DIV clocks.
- Debounce at frame end: compare the completed 16-bit frame with the previous frame.
  - Mismatch: stable_cnt=0.
  - Match: stable_cnt increments, saturating at DEBOUNCE.
  - When stable_cnt reaches DEBOUNCE and the frame differs from the debounced state, the debounced state takes the frame value.
  - In all cases the previous frame takes the frame value.
- key_down = OR of the debounced state, registered. It updates on the clock after the debounced state updates.
- Press event: fires on a debounced update where the old debounced state was 0 and the new state has exactly one bit set.
  - Code is that bit index.
  - Zero-to-multiple-key transitions, and changes while any key is held, generate no event (anti-ghosting, no rollover).
  - A release to 0 re-arms press detection.
- Holding register, evaluated one clock after the debounced update:
  - event and key_valid=0: key_code=code, key_valid=1.
  - event, key_valid=1, key_ack=1 in the same clock: key_code=new code, key_valid stays 1, overrun=0.
  - event, key_valid=1, key_ack=0: key_code unchanged, overrun=1.
  - key_ack with no event: key_valid=0, overrun=0.
  - key_ack while key_valid=0: ignored.
- Press latency, from stable rows at the pins to key_valid: at most (DEBOUNCE+2) frames + 4 clocks.

Decomposition:
- Shared package debug_pkg holds: column reset pattern 4'b1110, KEY_W=4, FRAME_W=16, and a popcount-is-one function.
- One natural sub-module: debug_sync2 (2-flop synchronizer, width parameter). The display and keypad modules can reuse it.
- Prescaler, scanner, debouncer and holding register all stay in debug_keypad.

Test Plan:
- Bench config: SCAN_DIV=4, DEBOUNCE=3, frame = 16 clocks.
- Reset then idle with rows=4'hF: col cycles 1110,1101,1011,0111 with each value held 4 clocks; key_valid=0, key_down=0 throughout.
- Hold key 6 (row[2] low only while col[1] is low): key_code=6 and key_valid=1 within 80 clocks; key_down=1. Pulse key_ack: key_valid=0 next clock.
- Bounce key 6 by toggling row[2] every 10 clocks for 100 clocks, then hold: exactly one event, code 6.
- Press key 6 then key 9 at the same time: no event for 9. Release all, then press 9: key_code=9.
- Press 3 without ack, release, press 12: key_code stays 3 and overrun=1. key_ack clears both flags. Second pass with key_ack in the same clock as the 12 event: key_code=12, key_valid=1, overrun=0.
- Assert reset mid-frame while key 5 is held and debounced: all outputs return to reset values and col=1110. After release of reset, the press is re-detected as a fresh event with code 5.
